// File: rtl/load_store_unit.sv
// Memory-access stage: one req/gnt/rvalid transaction per load or store, with byte-lane
// steering and sign/zero-extended load results. Define MISALIGN_TRAP_EN to trap misaligned accesses.
module load_store_unit #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int FUNCTION3 = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load_i,
    input  logic                 store_i,
    input  logic [FUNCTION3-1:0] fun3_i,
    input  logic [ADDR_W-1:0]    addr_i,
    input  logic [DATA_W-1:0]    wdata_i,
    output logic                 stall_o,
    output logic [DATA_W-1:0]    load_data_o,
    output logic                 done_o,
    output logic                 misalign_o,
    output logic                 mem_req_o,
    output logic                 mem_we_o,
    output logic [ADDR_W-1:0]    mem_addr_o,
    output logic [3:0]           mem_be_o,
    output logic [DATA_W-1:0]    mem_wdata_o,
    input  logic                 mem_gnt_i,
    input  logic                 mem_rvalid_i,
    input  logic [DATA_W-1:0]    mem_rdata_i
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    localparam logic [FUNCTION3-1:0] F3_B  = FUNCTION3'(3'b000);
    localparam logic [FUNCTION3-1:0] F3_H  = FUNCTION3'(3'b001);
    localparam logic [FUNCTION3-1:0] F3_W  = FUNCTION3'(3'b010);
    localparam logic [FUNCTION3-1:0] F3_BU = FUNCTION3'(3'b100);
    localparam logic [FUNCTION3-1:0] F3_HU = FUNCTION3'(3'b101);

    state_t                state_q, state_d;
    logic [ADDR_W-1:0]     addr_q;
    logic [FUNCTION3-1:0]  fun3_q;
    logic                  we_q;
    logic [3:0]            be_q, be_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic [DATA_W-1:0]     load_data_q;
    logic                  access, legal_store, legal_load, access_legal, misaligned;
    logic                  capture;

    function automatic logic [DATA_W-1:0] extend_load(input logic [FUNCTION3-1:0] f3,
                                                      input logic [1:0]           off,
                                                      input logic [DATA_W-1:0]    rdata);
        logic [7:0]  b;
        logic [15:0] h;
        b = rdata[{off, 3'b000} +: 8];
        h = rdata[{off[1], 4'b0000} +: 16];
        case (f3)
            F3_B:    return {{(DATA_W-8){b[7]}}, b};
            F3_H:    return {{(DATA_W-16){h[15]}}, h};
            F3_W:    return rdata;
            F3_BU:   return {{(DATA_W-8){1'b0}}, b};
            F3_HU:   return {{(DATA_W-16){1'b0}}, h};
            default: return '0;
        endcase
    endfunction

    // Decode of the incoming strobe: a simultaneous load and store is treated as a store.
    always_comb begin
        access       = load_i | store_i;
        legal_store  = (fun3_i == F3_B) || (fun3_i == F3_H) || (fun3_i == F3_W);
        legal_load   = legal_store || (fun3_i == F3_BU) || (fun3_i == F3_HU);
        access_legal = store_i ? legal_store : legal_load;

        case (fun3_i[1:0])
            2'b00:   be_d = 4'b0001 << addr_i[1:0];
            2'b01:   be_d = 4'b0011 << {addr_i[1], 1'b0};
            default: be_d = 4'b1111;
        endcase

        case (fun3_i[1:0])
            2'b00:   wdata_d = {(DATA_W/8){wdata_i[7:0]}};
            2'b01:   wdata_d = {(DATA_W/16){wdata_i[15:0]}};
            default: wdata_d = wdata_i;
        endcase
    end

`ifdef MISALIGN_TRAP_EN
    logic misalign_q;

    assign misaligned = access_legal &&
                        (((fun3_i[1:0] == 2'b01) && addr_i[0]) ||
                         ((fun3_i[1:0] == 2'b10) && (addr_i[1:0] != 2'b00)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign_q <= 1'b0;
        end else if (state_q == IDLE && access) begin
            misalign_q <= misaligned;
        end
    end

    assign misalign_o = (state_q == DONE) && misalign_q;
`else
    assign misaligned = 1'b0;
    assign misalign_o = 1'b0;
`endif

    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        stall_o   = 1'b0;
        done_o    = 1'b0;
        mem_req_o = 1'b0;
        capture   = 1'b0;
        case (state_q)
            IDLE: begin
                if (access) begin
                    stall_o = 1'b1;
                    state_d = (access_legal && !misaligned) ? REQ : DONE;
                end
            end
            REQ: begin
                stall_o   = 1'b1;
                mem_req_o = 1'b1;
                if (mem_gnt_i) begin
                    if (we_q) begin
                        state_d = DONE;
                    end else if (mem_rvalid_i) begin
                        capture = 1'b1;
                        state_d = DONE;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                stall_o = 1'b1;
                if (mem_rvalid_i) begin
                    capture = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                done_o  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: the latched request is reset too, so bus outputs read as zero straight out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q      <= '0;
            fun3_q      <= '0;
            we_q        <= 1'b0;
            be_q        <= '0;
            wdata_q     <= '0;
            load_data_q <= '0;
        end else begin
            if (state_q == IDLE && access) begin
                addr_q  <= addr_i;
                fun3_q  <= fun3_i;
                we_q    <= store_i;
                be_q    <= be_d;
                wdata_q <= wdata_d;
                if (!store_i && !access_legal) begin
                    load_data_q <= '0;
                end
            end
            if (capture) begin
                load_data_q <= extend_load(fun3_q, addr_q[1:0], mem_rdata_i);
            end
        end
    end

    assign mem_we_o    = we_q;
    assign mem_addr_o  = {addr_q[ADDR_W-1:2], 2'b00};
    assign mem_be_o    = be_q;
    assign mem_wdata_o = wdata_q;
    assign load_data_o = load_data_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: byte-array memory model predicts bus traffic and
// load results; a randomised responder plays the data memory.
module tb_load_store_unit;

    localparam logic [31:0] BASE = 32'h100;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load_i, store_i;
    logic [2:0]  fun3_i;
    logic [31:0] addr_i, wdata_i;
    logic        stall_o, done_o, misalign_o, mem_req_o, mem_we_o;
    logic [31:0] load_data_o, mem_addr_o, mem_wdata_o;
    logic [3:0]  mem_be_o;
    logic        mem_gnt_i, mem_rvalid_i;
    logic [31:0] mem_rdata_i;

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } bus_item_t;

    typedef struct {
        logic [31:0] data;
        bit          misalign;
    } done_item_t;

    bus_item_t   bus_q[$];
    done_item_t  done_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [7:0]  model_mem [64];
    logic [31:0] model_last_load;
    logic [31:0] resp_mem [16];
    int          cfg_gnt  = -1;
    int          cfg_rv   = -1;
    bit          stale_en = 1'b0;

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .load_i       (load_i),
        .store_i      (store_i),
        .fun3_i       (fun3_i),
        .addr_i       (addr_i),
        .wdata_i      (wdata_i),
        .stall_o      (stall_o),
        .load_data_o  (load_data_o),
        .done_o       (done_o),
        .misalign_o   (misalign_o),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_be_o     (mem_be_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_gnt_i    (mem_gnt_i),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i)
    );

    task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, want, $time);
    endtask

    // Reference model: memory as bytes, accesses as byte runs from the effective address.
    task automatic model_issue(input bit ld, input bit st, input logic [2:0] f3,
                               input logic [31:0] a, input logic [31:0] wd);
        bit          legal, mis;
        int          size, off;
        logic [31:0] ea, val;
        bus_item_t   b;
        done_item_t  d;
        legal = st ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        size  = 1 << f3[1:0];
        mis   = 1'b0;
`ifdef MISALIGN_TRAP_EN
        if (legal) mis = ((a % 32'(size)) != 0);
`endif
        d.misalign = mis;
        if (!legal) begin
            if (!st && ld) model_last_load = '0;
            d.data = model_last_load;
        end else if (mis) begin
            d.data = model_last_load;
        end else begin
            ea      = a & ~32'(size - 1);
            off     = int'(ea - BASE);
            b.we    = st;
            b.addr  = {ea[31:2], 2'b00};
            b.be    = '0;
            b.wdata = '0;
            for (int i = 0; i < size; i++) b.be[int'(ea[1:0]) + i] = 1'b1;
            if (st) begin
                for (int i = 0; i < size; i++) model_mem[off + i] = wd[8*i +: 8];
                for (int j = 0; j < 4; j++) b.wdata[8*j +: 8] = wd[8*(j % size) +: 8];
                d.data = model_last_load;
            end else begin
                val = '0;
                for (int i = 0; i < size; i++) val[8*i +: 8] = model_mem[off + i];
                if (f3[2] == 1'b0 && size < 4 && val[8*size - 1]) val = val | (32'hFFFF_FFFF << (8*size));
                model_last_load = val;
                d.data          = val;
            end
            bus_q.push_back(b);
        end
        done_q.push_back(d);
    endtask

    task automatic issue(input bit ld, input bit st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, output int cyc, output bit stall_ok);
        bit seen;
        model_issue(ld, st, f3, a, wd);
        @(posedge clk);
        #1;
        load_i  = ld;
        store_i = st;
        fun3_i  = f3;
        addr_i  = a;
        wdata_i = wd;
        cyc      = 0;
        stall_ok = 1'b1;
        seen     = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done_o === 1'b1) begin
                seen = 1'b1;
                break;
            end
            cyc++;
            if (stall_o !== 1'b1) stall_ok = 1'b0;
        end
        if (!seen) check(1'b0, "done_timeout", 32'(cyc), 32'd100);
        @(posedge clk);
        #1;
        load_i  = 1'b0;
        store_i = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check(stall_o === 1'b0,      {tag, "_stall"},    32'(stall_o), 0);
        check(done_o === 1'b0,       {tag, "_done"},     32'(done_o), 0);
        check(misalign_o === 1'b0,   {tag, "_misalign"}, 32'(misalign_o), 0);
        check(mem_req_o === 1'b0,    {tag, "_req"},      32'(mem_req_o), 0);
        check(mem_we_o === 1'b0,     {tag, "_we"},       32'(mem_we_o), 0);
        check(mem_addr_o === '0,     {tag, "_addr"},     mem_addr_o, 0);
        check(mem_be_o === '0,       {tag, "_be"},       32'(mem_be_o), 0);
        check(mem_wdata_o === '0,    {tag, "_wdata"},    mem_wdata_o, 0);
        check(load_data_o === '0,    {tag, "_ldata"},    load_data_o, 0);
    endtask

    // Monitor: compares bus traffic and completions against the expectation queues.
    always @(negedge clk) begin
        done_item_t e;
        bus_item_t  b;
        if (rst_n === 1'b1) begin
            if (done_o === 1'b1) begin
                if (done_q.size() == 0) begin
                    check(1'b0, "unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = done_q.pop_front();
                    check(load_data_o === e.data, "load_data", load_data_o, e.data);
                    check(misalign_o === e.misalign, "misalign", 32'(misalign_o), 32'(e.misalign));
                    check(stall_o === 1'b0, "stall_in_done", 32'(stall_o), 0);
                end
            end
            if (mem_req_o === 1'b1) begin
                if (bus_q.size() == 0) begin
                    check(1'b0, "unexpected_req", mem_addr_o, 0);
                end else begin
                    b = bus_q[0];
                    check(mem_addr_o === b.addr, "bus_addr", mem_addr_o, b.addr);
                    check({mem_we_o, mem_be_o} === {b.we, b.be}, "bus_we_be",
                          32'({mem_we_o, mem_be_o}), 32'({b.we, b.be}));
                    if (b.we) check(mem_wdata_o === b.wdata, "bus_wdata", mem_wdata_o, b.wdata);
                    if (mem_gnt_i === 1'b1) void'(bus_q.pop_front());
                end
            end
        end
    end

    // Data-memory responder: configurable or random grant and read-data delays.
    initial begin
        int          gnt_wait, gnt_target, pend, rv;
        logic [31:0] pend_data;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = '0;
        pend         = -1;
        gnt_wait     = 0;
        gnt_target   = 0;
        pend_data    = '0;
        forever begin
            @(posedge clk);
            #2;
            mem_gnt_i    = 1'b0;
            mem_rvalid_i = 1'b0;
            mem_rdata_i  = $urandom;
            if (pend == 0) begin
                mem_rvalid_i = 1'b1;
                mem_rdata_i  = pend_data;
                pend         = -1;
            end else if (pend > 0) begin
                pend--;
            end else if (mem_req_o === 1'b1) begin
                if (gnt_wait == 0) gnt_target = (cfg_gnt < 0) ? int'($urandom_range(0, 3)) : cfg_gnt;
                if (gnt_wait >= gnt_target) begin
                    mem_gnt_i = 1'b1;
                    gnt_wait  = 0;
                    if (mem_we_o === 1'b1) begin
                        for (int b = 0; b < 4; b++) begin
                            if (mem_be_o[b]) resp_mem[mem_addr_o[5:2]][8*b +: 8] = mem_wdata_o[8*b +: 8];
                        end
                    end else begin
                        rv = (cfg_rv < 0) ? int'($urandom_range(0, 3)) : cfg_rv;
                        if (rv == 0) begin
                            mem_rvalid_i = 1'b1;
                            mem_rdata_i  = resp_mem[mem_addr_o[5:2]];
                        end else begin
                            pend      = rv - 1;
                            pend_data = resp_mem[mem_addr_o[5:2]];
                        end
                    end
                end else begin
                    gnt_wait++;
                end
            end else if (stale_en && $urandom_range(0, 7) == 0) begin
                mem_rvalid_i = 1'b1;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, n_pass=%0d n_checks=%0d", n_pass, n_checks);
        $fatal(1);
    end

    initial begin
        int          cyc, exp_cyc, r;
        bit          sok, ld, st;
        logic [31:0] w;
        bus_item_t   bi;
        load_i  = 1'b0;
        store_i = 1'b0;
        fun3_i  = '0;
        addr_i  = '0;
        wdata_i = '0;
        rst_n   = 1'b1;
        model_last_load = '0;
        for (int i = 0; i < 16; i++) begin
            w = $urandom;
            resp_mem[i] = w;
            for (int k = 0; k < 4; k++) model_mem[4*i + k] = w[8*k +: 8];
        end
        #2 rst_n = 1'b0;
        #5;
        check_reset_outputs("reset");
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Directed cases
        cfg_gnt = 0;
        cfg_rv  = 0;
        issue(1'b0, 1'b1, 3'b010, 32'h104, 32'hDEADBEEF, cyc, sok);
        check(cyc == 2, "sw_latency", 32'(cyc), 32'd2);
        check(sok, "sw_stall", 32'(sok), 32'd1);
        issue(1'b0, 1'b1, 3'b000, 32'h103, 32'h000000A5, cyc, sok);
        issue(1'b0, 1'b1, 3'b010, 32'h100, 32'h80FF7F00, cyc, sok);
        cfg_rv = 3;
        issue(1'b1, 1'b0, 3'b000, 32'h102, 32'h0, cyc, sok);
        check(cyc == 5, "lb_latency", 32'(cyc), 32'd5);
        check(sok, "lb_stall_wait", 32'(sok), 32'd1);
        issue(1'b1, 1'b0, 3'b100, 32'h102, 32'h0, cyc, sok);
        check(sok, "lbu_stall_wait", 32'(sok), 32'd1);
        issue(1'b0, 1'b1, 3'b010, 32'h100, 32'h80017F00, cyc, sok);
        cfg_gnt = 4;
        cfg_rv  = 0;
        issue(1'b1, 1'b0, 3'b001, 32'h102, 32'h0, cyc, sok);
        check(cyc == 6, "lh_gnt_delay_latency", 32'(cyc), 32'd6);
        check(sok, "lh_stall", 32'(sok), 32'd1);

        // Reset while a load waits for read data; the late response must be ignored.
        cfg_gnt     = 0;
        cfg_rv      = 3;
        bi.we       = 1'b0;
        bi.addr     = 32'h108;
        bi.be       = 4'hF;
        bi.wdata    = '0;
        bus_q.push_back(bi);
        @(posedge clk);
        #1;
        load_i = 1'b1;
        fun3_i = 3'b010;
        addr_i = 32'h108;
        @(posedge clk);
        @(posedge clk);
        #1;
        load_i = 1'b0;
        check(stall_o === 1'b1, "stall_in_wait", 32'(stall_o), 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("reset_mid");
        @(posedge clk);
        #1 rst_n = 1'b1;
        model_last_load = '0;
        done_q.delete();
        bus_q.delete();
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check(load_data_o === '0 && done_o === 1'b0 && stall_o === 1'b0, "stale_rvalid_ignored",
              load_data_o, 32'h0);
        cfg_rv = 0;
        issue(1'b1, 1'b0, 3'b010, 32'h108, 32'h0, cyc, sok);
        check(cyc == 2, "lw_after_reset_latency", 32'(cyc), 32'd2);

        // Misaligned word load
`ifdef MISALIGN_TRAP_EN
        exp_cyc = 1;
`else
        exp_cyc = 2;
`endif
        issue(1'b1, 1'b0, 3'b010, 32'h101, 32'h0, cyc, sok);
        check(cyc == exp_cyc, "lw_misalign_latency", 32'(cyc), 32'(exp_cyc));

        // Randomised traffic, including illegal fun3 and stray read-data pulses.
        cfg_gnt  = -1;
        cfg_rv   = -1;
        stale_en = 1'b1;
        for (int n = 0; n < 300; n++) begin
            r  = int'($urandom_range(0, 7));
            st = (r <= 3);
            ld = (r == 0) || (r >= 4);
            issue(ld, st, 3'($urandom_range(0, 7)), BASE + 32'($urandom_range(0, 63)), $urandom, cyc, sok);
            check(sok, "rand_stall", 32'(sok), 32'd1);
        end
        stale_en = 1'b0;
        repeat (5) @(negedge clk);
        check(done_q.size() == 0 && bus_q.size() == 0, "queues_drained",
              32'(done_q.size() + bus_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-access stage placed directly downstream of the instruction decoder; consumes its Load/Store strobes and fun3, plus the ALU address and rs2 data.
- Runs one data-memory transaction per load or store over a req/gnt/rvalid bus.
- Generates byte enables and store-data lane replication; returns a sign- or zero-extended load result to the writeback mux.
- Holds stall_o high until the access completes.

Parameters:
- DATA_W, 32, data and load-result width
- ADDR_W, 32, byte address width
- FUNCTION3, 3, width of the fun3 field

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- load_i  input  1  load instruction in execute
- store_i  input  1  store instruction in execute
- fun3_i  input  FUNCTION3  access size/sign
- addr_i  input  ADDR_W  effective byte address (ALU result)
- wdata_i  input  DATA_W  store source (rs2)
- stall_o  output  1  hold PC and pipeline inputs
- load_data_o  output  DATA_W  extended load result, valid when done_o=1
- done_o  output  1  one-cycle access-complete pulse
- misalign_o  output  1  misaligned-access pulse (MISALIGN_TRAP_EN only, else tied 0)
- mem_req_o  output  1  bus request
- mem_we_o  output  1  1 = write
- mem_addr_o  output  ADDR_W  word-aligned address {addr[ADDR_W-1:2],2'b00}
- mem_be_o  output  4  byte enables
- mem_wdata_o  output  DATA_W  lane-replicated store data
- mem_gnt_i  input  1  request accepted
- mem_rvalid_i  input  1  read data valid
- mem_rdata_i  input  DATA_W  read data

Behaviour:
- Clock is clk; reset is rst_n, asynchronous and active-low.
- Reset: state=IDLE. All outputs 0. Latched addr/fun3/we/be/wdata cleared.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE:
  - On load_i|store_i: latch fun3, addr, we=store_i, be, wdata; go to REQ.
  - If load_i and store_i are both high, the access is a store.
  - stall_o is driven combinationally high in IDLE whenever load_i|store_i.
- REQ:
  - mem_req_o=1; bus outputs come from latched values and stay stable until gnt.
  - gnt & we: go to DONE.
  - gnt & !we & rvalid: capture data, go to DONE.
  - gnt & !we & !rvalid: go to WAIT.
  - No gnt: remain in REQ.
- WAIT: mem_req_o=0. On rvalid, capture and extend into load_data_o, then go to DONE.
- DONE: done_o=1, stall_o=0, load_data_o held; next state is IDLE. The core advances on this cycle, so the next instruction is seen in IDLE.
- stall_o = (IDLE & (load_i|store_i)) | REQ | WAIT.
- Minimum latency from strobe to done_o: store 2 cycles; load 2 cycles (rvalid with gnt), otherwise 3 or more.
- Byte enables:
  - SB (000): 4'b0001 << addr[1:0]
  - SH (001): 4'b0011 << {addr[1],1'b0}
  - SW (010): 4'b1111
- Store data: SB {4{wdata[7:0]}}, SH {2{wdata[15:0]}}, SW wdata.
- Load extract: select byte/half by addr[1:0]/addr[1]. LB/LH sign-extend, LBU(100)/LHU(101) zero-extend, LW full word.
- Illegal fun3 (store 011–111; load 011, 110, 111): no bus access; go IDLE→DONE directly; load_data_o=0.
- rvalid seen in IDLE or DONE is ignored, e.g. a stale response arriving after reset.
- Reset asserted mid-transaction: immediate return to IDLE, mem_req_o drops asynchronously, and the transaction is abandoned.
- load_data_o keeps its last value until the next load completes; stores do not change it.

Optional Feature:
- Macro: MISALIGN_TRAP_EN
- Enabled:
  - An access is misaligned if it is a halfword with addr[0]=1 or a word with addr[1:0]≠0.
  - A misaligned access is not issued. IDLE goes directly to DONE; misalign_o=1 and done_o=1 in that DONE cycle; load_data_o is unchanged.
- Disabled:
  - misalign_o is tied to 0.
  - Low address bits are ignored for halfword and word accesses: a halfword uses addr[1] only, and a word uses the whole word at the aligned address.

Test Plan:
- SW: addr=0x104, wdata=0xDEADBEEF, gnt on first REQ cycle → mem_we_o=1, mem_addr_o=0x104, be=1111, wdata=0xDEADBEEF; done_o 2 cycles after the strobe; stall_o high for exactly 2 cycles.
- SB: addr=0x103, wdata=0x000000A5 → be=1000, mem_wdata_o=0xA5A5A5A5.
- LB/LBU: addr=0x102, rdata=0x80FF7F00, rvalid 3 cycles after gnt → LB gives 0xFFFFFFFF; LBU gives 0x000000FF; stall_o held throughout WAIT.
- LH: addr=0x102, rdata=0x80017F00 → 0xFFFF8001; gnt delayed 4 cycles → mem_req_o and mem_addr_o stable for all 4 cycles.
- Reset in WAIT, then rvalid=1 one cycle after release → all outputs 0, stale response ignored, next LW completes normally.
- With MISALIGN_TRAP_EN, LW at addr=0x101 → no mem_req_o; misalign_o=done_o=1 on the cycle after the strobe.
